// File: rtl/sb_mac16.sv
// sb_mac16: configurable 16x16 multiply-accumulate slice.
// Two 16-bit add/sub accumulators (TOP = O[31:16], BOT = O[15:0]). The BOT
// carry-out can cascade into TOP so that the pair behaves as one 32-bit adder.
// Each multiply stage and each input has an optional register stage.
module sb_mac16 #(
    parameter bit       C_REG                    = 1'b0,
    parameter bit       A_REG                    = 1'b0,
    parameter bit       B_REG                    = 1'b0,
    parameter bit       D_REG                    = 1'b0,
    parameter bit       TOP_8x8_MULT_REG         = 1'b0,
    parameter bit       BOT_8x8_MULT_REG         = 1'b0,
    parameter bit       PIPELINE_16x16_MULT_REG1 = 1'b0,
    parameter bit       PIPELINE_16x16_MULT_REG2 = 1'b0,
    parameter bit [1:0] TOPOUTPUT_SELECT         = 2'b00,
    parameter bit [1:0] BOTOUTPUT_SELECT         = 2'b00,
    parameter bit       TOPADDSUB_UPPERINPUT     = 1'b0,
    parameter bit       BOTADDSUB_UPPERINPUT     = 1'b0,
    parameter bit [1:0] TOPADDSUB_LOWERINPUT     = 2'b00,
    parameter bit [1:0] BOTADDSUB_LOWERINPUT     = 2'b00,
    parameter bit [1:0] TOPADDSUB_CARRYSELECT    = 2'b00,
    parameter bit [1:0] BOTADDSUB_CARRYSELECT    = 2'b00,
    parameter bit       A_SIGNED                 = 1'b0,
    parameter bit       B_SIGNED                 = 1'b0
) (
    input  logic        CLK,
    input  logic        IRSTTOP,
    input  logic        IRSTBOT,
    input  logic        ORSTTOP,
    input  logic        ORSTBOT,
    input  logic        CE,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [15:0] C,
    input  logic [15:0] D,
    input  logic        AHOLD,
    input  logic        BHOLD,
    input  logic        CHOLD,
    input  logic        DHOLD,
    input  logic        OHOLDTOP,
    input  logic        OHOLDBOT,
    input  logic        OLOADTOP,
    input  logic        OLOADBOT,
    input  logic        ADDSUBTOP,
    input  logic        ADDSUBBOT,
    input  logic        CI,
    input  logic        ACCUMCI,
    input  logic        SIGNEXTIN,
    output logic [31:0] O,
    output logic        CO,
    output logic        ACCUMCO,
    output logic        SIGNEXTOUT
);

    logic [15:0] a_q, b_q, c_q, d_q;
    logic [15:0] a, b, c, d;
    logic signed [17:0] a_hi, a_lo, b_hi, b_lo;
    logic signed [17:0] pp_ll_c, pp_lh_c, pp_hl_c, pp_hh_c;
    logic signed [17:0] pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
    logic signed [17:0] pp_ll, pp_lh, pp_hl, pp_hh;
    logic [15:0] f_q, g_q, f, g;
    logic [31:0] h_c, h_q, h;
    logic [15:0] bot_u, bot_l, top_u, top_l;
    logic        bot_ci, top_ci;
    logic [16:0] bot_sum, top_sum;
    logic [15:0] acct_q, acct_d, accb_q, accb_d;

    function automatic logic [31:0] sext32(input logic [17:0] x);
        return {{14{x[17]}}, x};
    endfunction

    // Top-side input registers (A, C): load when enabled and not held
    always_ff @(posedge CLK or posedge IRSTTOP) begin
        if (IRSTTOP) begin
            a_q <= '0;
            c_q <= '0;
        end else if (CE) begin
            if (!AHOLD) a_q <= A;
            if (!CHOLD) c_q <= C;
        end
    end

    // Bottom-side input registers (B, D): load when enabled and not held
    always_ff @(posedge CLK or posedge IRSTBOT) begin
        if (IRSTBOT) begin
            b_q <= '0;
            d_q <= '0;
        end else if (CE) begin
            if (!BHOLD) b_q <= B;
            if (!DHOLD) d_q <= D;
        end
    end

    assign a = A_REG ? a_q : A;
    assign b = B_REG ? b_q : B;
    assign c = C_REG ? c_q : C;
    assign d = D_REG ? d_q : D;

    // High bytes carry the operand sign when signed; low bytes are always unsigned
    assign a_hi = {{10{A_SIGNED & a[15]}}, a[15:8]};
    assign b_hi = {{10{B_SIGNED & b[15]}}, b[15:8]};
    assign a_lo = {10'd0, a[7:0]};
    assign b_lo = {10'd0, b[7:0]};

    assign pp_ll_c = a_lo * b_lo;
    assign pp_lh_c = a_lo * b_hi;
    assign pp_hl_c = a_hi * b_lo;
    assign pp_hh_c = a_hi * b_hi;

    // F product register (top 8x8)
    always_ff @(posedge CLK or posedge IRSTTOP) begin
        if (IRSTTOP)  f_q <= '0;
        else if (CE)  f_q <= pp_hh_c[15:0];
    end

    // G product and 16x16 pipeline registers, all on the bottom reset
    always_ff @(posedge CLK or posedge IRSTBOT) begin
        if (IRSTBOT) begin
            g_q     <= '0;
            pp_ll_q <= '0;
            pp_lh_q <= '0;
            pp_hl_q <= '0;
            pp_hh_q <= '0;
            h_q     <= '0;
        end else if (CE) begin
            g_q     <= pp_ll_c[15:0];
            pp_ll_q <= pp_ll_c;
            pp_lh_q <= pp_lh_c;
            pp_hl_q <= pp_hl_c;
            pp_hh_q <= pp_hh_c;
            h_q     <= h_c;
        end
    end

    assign f     = TOP_8x8_MULT_REG ? f_q : pp_hh_c[15:0];
    assign g     = BOT_8x8_MULT_REG ? g_q : pp_ll_c[15:0];
    assign pp_ll = PIPELINE_16x16_MULT_REG1 ? pp_ll_q : pp_ll_c;
    assign pp_lh = PIPELINE_16x16_MULT_REG1 ? pp_lh_q : pp_lh_c;
    assign pp_hl = PIPELINE_16x16_MULT_REG1 ? pp_hl_q : pp_hl_c;
    assign pp_hh = PIPELINE_16x16_MULT_REG1 ? pp_hh_q : pp_hh_c;

    // Full product: shifted sum of the four (sign-extended) partials, modulo 2^32
    assign h_c = (sext32(pp_hh) << 16) + ((sext32(pp_lh) + sext32(pp_hl)) << 8) + sext32(pp_ll);
    assign h   = PIPELINE_16x16_MULT_REG2 ? h_q : h_c;

    // Bottom adder: operand selection and add / subtract (U - L - cin)
    always_comb begin
        bot_u = BOTADDSUB_UPPERINPUT ? d : accb_q;
        case (BOTADDSUB_LOWERINPUT)
            2'd0:    bot_l = b;
            2'd1:    bot_l = g;
            2'd2:    bot_l = h[15:0];
            default: bot_l = {16{SIGNEXTIN}};
        endcase
        case (BOTADDSUB_CARRYSELECT)
            2'd0:    bot_ci = 1'b0;
            2'd1:    bot_ci = 1'b1;
            2'd2:    bot_ci = ACCUMCI;
            default: bot_ci = CI;
        endcase
        if (ADDSUBBOT) bot_sum = {1'b0, bot_u} + {1'b0, ~bot_l} + {16'd0, ~bot_ci};
        else           bot_sum = {1'b0, bot_u} + {1'b0, bot_l} + {16'd0, bot_ci};
    end

    // Top adder: may take the bottom carry / sign to form a 32-bit adder
    always_comb begin
        top_u = TOPADDSUB_UPPERINPUT ? c : acct_q;
        case (TOPADDSUB_LOWERINPUT)
            2'd0:    top_l = a;
            2'd1:    top_l = f;
            2'd2:    top_l = h[31:16];
            default: top_l = {16{bot_sum[15]}};
        endcase
        case (TOPADDSUB_CARRYSELECT)
            2'd0:    top_ci = 1'b0;
            2'd1:    top_ci = 1'b1;
            default: top_ci = bot_sum[16];
        endcase
        if (ADDSUBTOP) top_sum = {1'b0, top_u} + {1'b0, ~top_l} + {16'd0, ~top_ci};
        else           top_sum = {1'b0, top_u} + {1'b0, top_l} + {16'd0, top_ci};
    end

    assign acct_d = OLOADTOP ? c : top_sum[15:0];
    assign accb_d = OLOADBOT ? d : bot_sum[15:0];

    // Top accumulator: hold beats load; CE gates everything
    always_ff @(posedge CLK or posedge ORSTTOP) begin
        if (ORSTTOP)                 acct_q <= '0;
        else if (CE && !OHOLDTOP)    acct_q <= acct_d;
    end

    // Bottom accumulator: hold beats load; CE gates everything
    always_ff @(posedge CLK or posedge ORSTBOT) begin
        if (ORSTBOT)                 accb_q <= '0;
        else if (CE && !OHOLDBOT)    accb_q <= accb_d;
    end

    // Per-half output source selection
    always_comb begin
        case (TOPOUTPUT_SELECT)
            2'd0:    O[31:16] = top_sum[15:0];
            2'd1:    O[31:16] = acct_q;
            2'd2:    O[31:16] = f;
            default: O[31:16] = h[31:16];
        endcase
        case (BOTOUTPUT_SELECT)
            2'd0:    O[15:0] = bot_sum[15:0];
            2'd1:    O[15:0] = accb_q;
            2'd2:    O[15:0] = g;
            default: O[15:0] = h[15:0];
        endcase
    end

    assign CO         = top_sum[16];
    assign ACCUMCO    = top_sum[16];
    assign SIGNEXTOUT = a[15];

endmodule

// File: tb/tb_sb_mac16.sv
// Directed bench for sb_mac16: u0 in the FIR accumulate configuration,
// u1 as a registered-A signed multiplier with combinational H output.
module tb_sb_mac16;
    logic        CLK = 1'b0;
    logic        IRSTTOP, IRSTBOT, ORSTTOP, ORSTBOT, CE;
    logic [15:0] A, B, C, D, A1, B1;
    logic        AHOLD, BHOLD, CHOLD, DHOLD, OHOLDTOP, OHOLDBOT, OLOADTOP, OLOADBOT;
    logic        ADDSUBTOP, ADDSUBBOT, CI, ACCUMCI, SIGNEXTIN;
    logic [31:0] O0, O1;
    logic        CO0, ACO0, SX0, CO1, ACO1, SX1;
    int          checks = 0;
    int          failures = 0;

    always #5 CLK = ~CLK;

    sb_mac16 #(
        .PIPELINE_16x16_MULT_REG2(1'b1), .TOPOUTPUT_SELECT(2'd1), .BOTOUTPUT_SELECT(2'd1),
        .TOPADDSUB_LOWERINPUT(2'd2), .BOTADDSUB_LOWERINPUT(2'd2),
        .TOPADDSUB_CARRYSELECT(2'd2), .A_SIGNED(1'b1)
    ) u0 (
        .CLK(CLK), .IRSTTOP(IRSTTOP), .IRSTBOT(IRSTBOT), .ORSTTOP(ORSTTOP), .ORSTBOT(ORSTBOT),
        .CE(CE), .A(A), .B(B), .C(C), .D(D), .AHOLD(AHOLD), .BHOLD(BHOLD), .CHOLD(CHOLD),
        .DHOLD(DHOLD), .OHOLDTOP(OHOLDTOP), .OHOLDBOT(OHOLDBOT), .OLOADTOP(OLOADTOP),
        .OLOADBOT(OLOADBOT), .ADDSUBTOP(ADDSUBTOP), .ADDSUBBOT(ADDSUBBOT), .CI(CI),
        .ACCUMCI(ACCUMCI), .SIGNEXTIN(SIGNEXTIN), .O(O0), .CO(CO0), .ACCUMCO(ACO0),
        .SIGNEXTOUT(SX0)
    );

    sb_mac16 #(
        .A_REG(1'b1), .TOPOUTPUT_SELECT(2'd3), .BOTOUTPUT_SELECT(2'd3), .A_SIGNED(1'b1)
    ) u1 (
        .CLK(CLK), .IRSTTOP(IRSTTOP), .IRSTBOT(IRSTBOT), .ORSTTOP(ORSTTOP), .ORSTBOT(ORSTBOT),
        .CE(CE), .A(A1), .B(B1), .C(C), .D(D), .AHOLD(AHOLD), .BHOLD(BHOLD), .CHOLD(CHOLD),
        .DHOLD(DHOLD), .OHOLDTOP(OHOLDTOP), .OHOLDBOT(OHOLDBOT), .OLOADTOP(OLOADTOP),
        .OLOADBOT(OLOADBOT), .ADDSUBTOP(ADDSUBTOP), .ADDSUBBOT(ADDSUBBOT), .CI(CI),
        .ACCUMCI(ACCUMCI), .SIGNEXTIN(SIGNEXTIN), .O(O1), .CO(CO1), .ACCUMCO(ACO1),
        .SIGNEXTOUT(SX1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Load both accumulators with {c, d} while the multiplier sees 0
    task automatic load_acc(input logic [15:0] c, input logic [15:0] d);
        OLOADTOP = 1'b1; OLOADBOT = 1'b1; C = c; D = d; A = '0; B = '0;
        tick();
        OLOADTOP = 1'b0; OLOADBOT = 1'b0;
    endtask

    initial begin
        IRSTTOP = 1; IRSTBOT = 1; ORSTTOP = 1; ORSTBOT = 1; CE = 1;
        A = '0; B = '0; C = '0; D = '0; A1 = '0; B1 = '0;
        AHOLD = 0; BHOLD = 0; CHOLD = 0; DHOLD = 0; OHOLDTOP = 0; OHOLDBOT = 0;
        OLOADTOP = 0; OLOADBOT = 0; ADDSUBTOP = 0; ADDSUBBOT = 0;
        CI = 0; ACCUMCI = 0; SIGNEXTIN = 0;
        #3;
        chk("reset_u0_O", O0, 32'h0);
        chk("reset_u1_O", O1, 32'h0);
        @(negedge CLK);
        IRSTTOP = 0; IRSTBOT = 0; ORSTTOP = 0; ORSTBOT = 0;

        // FIR accumulate: 2-edge latency then +15 per edge
        load_acc(16'h0, 16'h0);
        chk("fir_load", O0, 32'd0);
        A = 16'h0003; B = 16'h0005;
        tick(); chk("fir_e1", O0, 32'd0);
        tick(); chk("fir_e2", O0, 32'd15);
        tick(); chk("fir_e3", O0, 32'd30);
        tick(); chk("fir_e4", O0, 32'd45);
        chk("fir_co", {31'd0, CO0}, 32'd0);

        // Accumulator hold for 3 edges
        OHOLDTOP = 1; OHOLDBOT = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("ohold", O0, 32'd45);
        end
        OHOLDTOP = 0; OHOLDBOT = 0;

        // Signed A times unsigned B, registered A, combinational H
        A1 = 16'hFFFF; B1 = 16'h0002;
        tick();
        chk("signed_m1x2", O1, 32'hFFFF_FFFE);
        chk("signextout", {31'd0, SX1}, 32'd1);
        B1 = 16'h0003;
        #1; chk("signed_comb_b", O1, 32'hFFFF_FFFD);
        CE = 0; A1 = 16'h0001;
        tick(); chk("ce0_areg_hold", O1, 32'hFFFF_FFFD);
        CE = 1;
        tick(); chk("ce1_areg_load", O1, 32'd3);

        // Carry cascade from BOT into TOP
        load_acc(16'h0000, 16'hFFFF);
        chk("casc_load", O0, 32'h0000_FFFF);
        A = 16'h0001; B = 16'h0001;
        tick(); chk("casc_e1", O0, 32'h0000_FFFF);
        tick(); chk("casc_e2", O0, 32'h0001_0000);

        // Subtract: 10 - 3 in the bottom half
        load_acc(16'h0000, 16'd10);
        ADDSUBTOP = 1; ADDSUBBOT = 1; OHOLDTOP = 1; OHOLDBOT = 1;
        A = 16'd3; B = 16'd1;
        tick(); chk("sub_held", O0, 32'd10);
        OHOLDTOP = 0; OHOLDBOT = 0;
        tick(); chk("sub_bot", {16'd0, O0[15:0]}, 32'd7);
        ADDSUBTOP = 0; ADDSUBBOT = 0;

        // 32-bit wrap: carry appears on CO, accumulator wraps to 0
        load_acc(16'hFFFF, 16'hFFFF);
        A = 16'h0001; B = 16'h0001;
        tick(); chk("wrap_pre", O0, 32'hFFFF_FFFF);
        chk("wrap_co", {30'd0, CO0, ACO0}, 32'd3);
        tick(); chk("wrap_post", O0, 32'h0);

        // Async output reset of top half mid-cycle
        load_acc(16'h1234, 16'h5678);
        chk("orst_pre", O0, 32'h1234_5678);
        #2 ORSTTOP = 1;
        #1 chk("orsttop_async", O0, 32'h0000_5678);
        ORSTBOT = 1;
        @(negedge CLK);
        ORSTTOP = 0; ORSTBOT = 0;

        // IRSTBOT clears the registered H: nothing gets accumulated afterwards
        OHOLDTOP = 1; OHOLDBOT = 1; A = 16'd2; B = 16'd3;
        tick();
        A = '0; B = '0;
        #1 IRSTBOT = 1;
        #1 IRSTBOT = 0;
        OHOLDTOP = 0; OHOLDBOT = 0;
        tick(); chk("irstbot_h", O0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sb_mac16.md
# sb_mac16

Configurable 16x16 multiply-accumulate DSP slice, split into TOP (bits 31:16) and BOT (bits 15:0) halves. It provides optional input registers, 8x8 and 16x16 multipliers with optional pipelining, two 16-bit add/sub accumulators with carry cascade, and a selectable 32-bit output. FIR filter blocks use it as the per-tap MAC engine, typically configured as a signed-coefficient by unsigned-sample multiplier feeding a registered 32-bit accumulator.

## Interface
Parameters (all static):
- C_REG, A_REG, B_REG, D_REG, 0: 1 registers that input.
- TOP_8x8_MULT_REG, BOT_8x8_MULT_REG, 0: 1 registers the F / G 8x8 products.
- PIPELINE_16x16_MULT_REG1, 0: 1 registers the four 8x8 partial products feeding H.
- PIPELINE_16x16_MULT_REG2, 0: 1 registers the 32-bit product H.
- TOPOUTPUT_SELECT, BOTOUTPUT_SELECT, 2'b00: half-output source. 0 = adder combinational, 1 = accumulator register, 2 = 8x8 product (F top / G bot), 3 = H half (H[31:16] / H[15:0]).
- TOPADDSUB_UPPERINPUT, BOTADDSUB_UPPERINPUT, 0: upper adder operand. 0 = own accumulator register, 1 = C (top) / D (bot).
- TOPADDSUB_LOWERINPUT, BOTADDSUB_LOWERINPUT, 2'b00: lower adder operand. 0 = A (top) / B (bot), 1 = F / G, 2 = H[31:16] / H[15:0], 3 = {16{BOT result bit 15}} (top) / {16{SIGNEXTIN}} (bot).
- TOPADDSUB_CARRYSELECT, BOTADDSUB_CARRYSELECT, 2'b00: carry-in. 0 = 0, 1 = 1. For top, 2 and 3 = BOT adder carry-out. For bottom, 2 = ACCUMCI, 3 = CI.
- A_SIGNED, B_SIGNED, 0: operand signedness for multiplies.

Ports:
- CLK, in, 1: only clock, rising edge.
- IRSTTOP, in, 1: async active-high reset of A and C registers and the F pipeline register.
- IRSTBOT, in, 1: async active-high reset of B and D registers, the G pipeline register, and the H pipeline registers.
- ORSTTOP, ORSTBOT, in, 1: async active-high reset of the top / bottom accumulator registers.
- CE, in, 1: global clock enable. When 0, all registers hold.
- A, B, C, D, in, 16: multiplicand, multiplier, top addend, bottom addend.
- AHOLD, BHOLD, CHOLD, DHOLD, in, 1: hold the corresponding input register.
- OHOLDTOP, OHOLDBOT, in, 1: hold the accumulator register.
- OLOADTOP, OLOADBOT, in, 1: load C / D into the accumulator instead of the adder result.
- ADDSUBTOP, ADDSUBBOT, in, 1: 0 = add, 1 = subtract.
- CI, ACCUMCI, SIGNEXTIN, in, 1: cascade carry and sign inputs.
- O, out, 32: {top half, bottom half}.
- CO, ACCUMCO, out, 1: top adder carry-out, both driven identically.
- SIGNEXTOUT, out, 1: A operand bit 15.

## Operation
- An input register loads on a rising edge when CE=1 and its HOLD=0. With *_REG=0 the path is combinational.
- Operand sign extension: A[15:8] is sign-extended if A_SIGNED, B[15:8] if B_SIGNED. Low bytes are always unsigned.
- Products: F = A[15:8]*B[15:8] (16 b). G = A[7:0]*B[7:0] (16 b). H = full 32-bit product A*B using the same signedness, built from four 8x8 partials.
- Adder: add = U + L + cin. Subtract = U + ~L + ~cin (U − L − cin). Results are 16 b; carry-out is bit 16 of the raw sum. The BOT carry-out feeds the TOP carry-select, so TOP:BOT forms a 32-bit adder when configured.
- Accumulator register update requires CE=1 and OHOLD=0. Load value is C (top) / D (bot) when OLOAD=1, else the adder result. In the upper operand, the register value is the accumulator itself (feedback).
- Output multiplexing per OUTPUT_SELECT. Registered-product selections take the registered version when the matching *_MULT_REG=1.

## Timing
- At reset, every register reset by the asserted line is 0 immediately, independent of CLK/CE. Resets override hold/load. O reflects cleared registers combinationally.
- Multiply-to-accumulate latency with the FIR configuration (A_REG=B_REG=0, REG1=0, REG2=1, OUTPUT_SELECT=1, LOWERINPUT=2, TOP CARRYSELECT=2) is 2 edges:
  - H is captured at edge n+1.
  - O = O + H at edge n+2.
- With combinational select 0 and no registers, O changes in the same cycle as inputs.
- Simultaneous OLOAD and OHOLD: hold wins.
- CE=0 with OLOAD=1: no change.
- Wrap-around: the accumulator is modulo 2^32 (or 2^16 per half if not cascaded). The carry is exposed on CO, never saturated.

## Test plan
- FIR configuration: ORST* pulse, then OLOAD*=1, C=D=0 for one edge, then A=0x0003, B=0x0005 held. Required O sequence: 0, 15, 30, 45. CO=0.
- Signed A: A=0xFFFF (−1), B=0x0002, A_SIGNED=1, B_SIGNED=0, OUTPUT_SELECT=3, REG2=0 -> O=0xFFFFFFFE combinationally.
- Carry cascade: accumulator=0x0000FFFF, H=0x00000001, add -> O=0x00010000.
- Subtract: ADDSUB*=1, accumulator at 10, H=3 -> O becomes 7 next accumulate edge.
- Holds: OHOLDTOP=OHOLDBOT=1 for 3 edges -> O unchanged. Then CE=0 with AHOLD=0 -> A register unchanged.
- Async reset: assert ORSTTOP mid-cycle with O=0x12345678 -> O=0x00005678 before the next edge. IRSTBOT clears B, D, G and H pipelines.
